sobel_edge_isp: RTL and testbench

Streaming Sobel edge detector for the camera ISP path. It accepts one 8-bit luma (Y) pixel per wr_en strobe, raster order, fixed line width. It builds a 3x3 window from two internal line buffers and computes the gradient magnitude |Gx|+|Gy|. Each result is thresholded to a binary RGB565 pixel: white or black. It sits between the RGB-to-Y conversion and the display/SDRAM write path.

---
 rtl/sobel_edge_isp.sv | 139 +++++++++++++
 tb/tb_sobel_edge_isp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_isp.sv
// Streaming 3x3 Sobel edge detector: two cascaded line buffers build the
// window, then a three-stage pipeline produces a thresholded RGB565 pixel.
module sobel_edge_isp #(
    parameter int CNT_PIC_MAX     = 639,
    parameter int SOBEL_THRESHOLD = 80
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        wr_en,
    input  logic [7:0]  img_Y,
    output logic [15:0] sobel_data,
    output logic        sobel_wr_en
);

    localparam int CW    = (CNT_PIC_MAX < 1) ? 1 : $clog2(CNT_PIC_MAX + 1);
    localparam int DEPTH = CNT_PIC_MAX + 1;

    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [1:0]    row_cnt_q, row_cnt_d;

    logic [7:0] lb1_mem [DEPTH];
    logic [7:0] lb2_mem [DEPTH];
    logic [7:0] lb1_rd, lb2_rd;

    logic [7:0] p11_q, p12_q, p13_q;
    logic [7:0] p21_q, p22_q, p23_q;
    logic [7:0] p31_q, p32_q, p33_q;

    logic        win_vld_d, v1_q, v2_q, v3_q;
    logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
    logic [10:0] gx_q, gy_q;
    logic [9:0]  ax_d, ay_d, ax_q, ay_q;
    logic [10:0] mag_d;
    logic [15:0] sobel_data_q;
    logic        sobel_wr_en_q;

    // Column/row position of the pixel being accepted; row saturates at 2
    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        if (wr_en) begin
            if (col_cnt_q == CW'(CNT_PIC_MAX)) begin
                col_cnt_d = '0;
                if (row_cnt_q != 2'd2) begin
                    row_cnt_d = row_cnt_q + 2'd1;
                end
            end else begin
                col_cnt_d = col_cnt_q + CW'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
        end else begin
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    // Read-before-write taps: previous row and two rows back, same column
    assign lb1_rd = lb1_mem[col_cnt_q];
    assign lb2_rd = lb2_mem[col_cnt_q];

    // Line buffers are not reset; row gating hides stale contents
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            lb1_mem[col_cnt_q] <= img_Y;
            lb2_mem[col_cnt_q] <= lb1_rd;
        end
    end

    // Window is valid once two full rows and two columns are behind us
    assign win_vld_d = wr_en && (row_cnt_q == 2'd2) && (col_cnt_q >= CW'(2));

    // 3x3 window shift; row 1 is the oldest line
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            p11_q <= '0; p12_q <= '0; p13_q <= '0;
            p21_q <= '0; p22_q <= '0; p23_q <= '0;
            p31_q <= '0; p32_q <= '0; p33_q <= '0;
            v1_q  <= 1'b0;
        end else begin
            v1_q <= win_vld_d;
            if (wr_en) begin
                p11_q <= p12_q; p12_q <= p13_q; p13_q <= lb2_rd;
                p21_q <= p22_q; p22_q <= p23_q; p23_q <= lb1_rd;
                p31_q <= p32_q; p32_q <= p33_q; p33_q <= img_Y;
            end
        end
    end

    // Kernel partial sums; each fits in 10 bits, 11-bit difference is signed
    always_comb begin
        gx_pos = {3'b0, p13_q} + {2'b0, p23_q, 1'b0} + {3'b0, p33_q};
        gx_neg = {3'b0, p11_q} + {2'b0, p21_q, 1'b0} + {3'b0, p31_q};
        gy_pos = {3'b0, p11_q} + {2'b0, p12_q, 1'b0} + {3'b0, p13_q};
        gy_neg = {3'b0, p31_q} + {2'b0, p32_q, 1'b0} + {3'b0, p33_q};
    end

    // Absolute values; |G| <= 1020 so the low 10 bits carry the magnitude
    always_comb begin
        ax_d  = gx_q[10] ? (~gx_q[9:0] + 10'd1) : gx_q[9:0];
        ay_d  = gy_q[10] ? (~gy_q[9:0] + 10'd1) : gy_q[9:0];
        mag_d = {1'b0, ax_q} + {1'b0, ay_q};
    end

    // Gradient, absolute-value and threshold stages with their valid bits
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            gx_q          <= '0;
            gy_q          <= '0;
            v2_q          <= 1'b0;
            ax_q          <= '0;
            ay_q          <= '0;
            v3_q          <= 1'b0;
            sobel_data_q  <= '0;
            sobel_wr_en_q <= 1'b0;
        end else begin
            gx_q          <= gx_pos - gx_neg;
            gy_q          <= gy_pos - gy_neg;
            v2_q          <= v1_q;
            ax_q          <= ax_d;
            ay_q          <= ay_d;
            v3_q          <= v2_q;
            sobel_wr_en_q <= v3_q;
            if (v3_q) begin
                sobel_data_q <= (mag_d > 11'(SOBEL_THRESHOLD)) ? 16'hFFFF : 16'h0000;
            end
        end
    end

    assign sobel_data  = sobel_data_q;
    assign sobel_wr_en = sobel_wr_en_q;

endmodule

// File: tb/tb_sobel_edge_isp.sv
// Bench for sobel_edge_isp with an 8-pixel line: a frame-level model keeps
// every accepted pixel and computes each window's gradient directly.
module tb_sobel_edge_isp;

    localparam int W   = 8;
    localparam int THR = 80;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        wr_en;
    logic [7:0]  img_Y;
    logic [15:0] sobel_data;
    logic        sobel_wr_en;

    sobel_edge_isp #(.CNT_PIC_MAX(W - 1), .SOBEL_THRESHOLD(THR)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .wr_en       (wr_en),
        .img_Y       (img_Y),
        .sobel_data  (sobel_data),
        .sobel_wr_en (sobel_wr_en)
    );

    always #5 sys_clk = ~sys_clk;

    int          errors = 0;
    int          checks = 0;
    int          pix[$];
    bit          pv[4];
    logic [15:0] pd[4];
    logic [15:0] exp_data;
    int          cyc = 0;
    int          strobes = 0;
    int          edges = 0;
    int          first_cyc = -1;
    int          acc18_cyc = -1;

    function automatic int px(int r, int c);
        return pix[r * W + c];
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        pix.delete();
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0;
            pd[i] = 16'h0000;
        end
        exp_data = 16'h0000;
    endtask

    // One clock: drive at negedge, update the model at posedge, check 1 ns later
    task automatic step(input logic we, input logic [7:0] y, input logic rst);
        bit          nv;
        logic [15:0] nd;
        int          n, r, c, gx, gy, mag;
        @(negedge sys_clk);
        wr_en   = we;
        img_Y   = y;
        sys_rst = rst;
        @(posedge sys_clk);
        cyc++;
        nv = 1'b0;
        nd = 16'h0000;
        if (rst) begin
            model_clear();
        end else begin
            if (we) begin
                n = pix.size();
                r = n / W;
                c = n % W;
                pix.push_back(int'(y));
                if (n == 18) acc18_cyc = cyc;
                if (r >= 2 && c >= 2) begin
                    gx = (px(r-2, c) + 2*px(r-1, c) + px(r, c))
                       - (px(r-2, c-2) + 2*px(r-1, c-2) + px(r, c-2));
                    gy = (px(r-2, c-2) + 2*px(r-2, c-1) + px(r-2, c))
                       - (px(r, c-2) + 2*px(r, c-1) + px(r, c));
                    mag = iabs(gx) + iabs(gy);
                    nv = 1'b1;
                    nd = (mag > THR) ? 16'hFFFF : 16'h0000;
                end
            end
            for (int i = 3; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = nv;
            pd[0] = nd;
            if (pv[3]) exp_data = pd[3];
        end
        #1;
        check("strobe", {15'd0, sobel_wr_en}, {15'd0, pv[3]});
        check("data", sobel_data, exp_data);
        if (sobel_wr_en === 1'b1) begin
            strobes++;
            if (sobel_data === 16'hFFFF) edges++;
            if (first_cyc < 0) first_cyc = cyc;
        end
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock
    task automatic rst_now();
        @(negedge sys_clk);
        #2;
        sys_rst = 1'b1;
        #1;
        check("rst_async_strobe", {15'd0, sobel_wr_en}, 16'd0);
        check("rst_async_data", sobel_data, 16'h0000);
        model_clear();
    endtask

    task automatic restart();
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        strobes   = 0;
        edges     = 0;
        first_cyc = -1;
        acc18_cyc = -1;
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) step(1'b0, 8'd0, 1'b0);
    endtask

    initial begin
        logic [7:0] cnt;
        int         guard;
        wr_en   = 1'b0;
        img_Y   = 8'd0;
        sys_rst = 1'b0;
        model_clear();
        #1 sys_rst = 1'b1;
        #1;
        check("reset_strobe", {15'd0, sobel_wr_en}, 16'd0);
        check("reset_data", sobel_data, 16'h0000);

        // Reset held for 200 ns while wr_en toggles
        for (int i = 0; i < 20; i++) step(1'(i % 2), 8'($urandom), 1'b1);

        // Ramp with alternating wr_en; includes the 255->0 rollover
        strobes = 0; edges = 0; first_cyc = -1; acc18_cyc = -1;
        cnt = 8'd0;
        for (int i = 0; i < 40 * W; i++) begin
            step(1'b1, cnt, 1'b0);
            step(1'b0, 8'($urandom), 1'b0);
            cnt = cnt + 8'd1;
        end
        drain();
        check("ramp_first_latency", 16'(first_cyc), 16'(acc18_cyc + 3));
        check("ramp_strobes", 16'(strobes), 16'(38 * 6));
        check("ramp_wrap_edges_seen", {15'd0, (edges > 0)}, 16'd1);

        // Flat image, back-to-back
        restart();
        for (int i = 0; i < 4 * W; i++) step(1'b1, 8'd100, 1'b0);
        drain();
        check("flat_strobes", 16'(strobes), 16'(2 * 6));
        check("flat_edges", 16'(edges), 16'd0);

        // Vertical step between cols 3 and 4
        restart();
        for (int i = 0; i < 5 * W; i++) step(1'b1, ((i % W) < 4) ? 8'd0 : 8'd200, 1'b0);
        drain();
        check("vstep_strobes", 16'(strobes), 16'(3 * 6));
        check("vstep_edges", 16'(edges), 16'(3 * 2));

        // Random rate, pixel values clustered near the threshold
        restart();
        guard = 0;
        while (pix.size() < 8 * W && guard < 2000) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 40)), 1'b0);
            guard++;
        end
        drain();
        check("random_done", {15'd0, (pix.size() == 8 * W)}, 16'd1);
        check("random_strobes", 16'(strobes), 16'(6 * 6));

        // Continuous stream, reset mid-row, then restart from row 0 col 0
        restart();
        for (int i = 0; i < 3 * W + 4; i++) step(1'b1, 8'($urandom), 1'b0);
        check("b2b_pre_reset_strobes", {15'd0, (strobes > 0)}, 16'd1);
        rst_now();
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b1);
        strobes = 0; edges = 0; first_cyc = -1; acc18_cyc = -1;
        for (int i = 0; i < 4 * W; i++) step(1'b1, 8'($urandom), 1'b0);
        drain();
        check("b2b_post_reset_latency", 16'(first_cyc), 16'(acc18_cyc + 3));
        check("b2b_post_reset_strobes", 16'(strobes), 16'(2 * 6));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
